// File: rtl/committer_nw.sv
// N-wide in-order commit stage: matches scoreboard-FIFO entries to EX pipeline
// outputs, retires the longest valid prefix and tracks the first fault.
package committer_nw_pkg;
    localparam int unsigned RegW  = 32;
    localparam int unsigned MaxPl = 4;

    typedef struct packed {
        logic [MaxPl:0] pl;
    } sbd_fifo_t;

    typedef struct packed {
        logic            err;
        logic            we;
        logic            wrsv;
        logic [4:0]      waddr;
        logic [RegW-1:0] wdata;
        logic [31:0]     pc;
        logic [31:0]     mcause;
        logic [31:0]     mtval;
    } pl_out_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] mcause;
        logic [31:0] mtval;
    } cmt_err_info_t;

    localparam cmt_err_info_t NULL_CMT_ERR_INFO = '0;
endpackage

module committer_nw
    import committer_nw_pkg::*;
#(
    parameter int unsigned CmtW      = 2,
    parameter int unsigned NumPl     = 4,
    parameter int unsigned LsPl      = 3,
    parameter bit          CHERIoTEn = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [CmtW-1:0]            sbdfifo_rd_valid_i,
    input  sbd_fifo_t [CmtW-1:0]       sbdfifo_rdata_i,
    output logic [CmtW-1:0]            sbdfifo_rd_rdy_o,
    input  logic [NumPl-1:0]           pl_valid_i,
    input  pl_out_t [NumPl-1:0]        pl_output_i,
    output logic [NumPl-1:0]           pl_rdy_o,
    input  logic                       cmt_flush_i,
    output logic [31:0]                cmt_regwr_o,
    output logic                       cmt_err_o,
    output cmt_err_info_t              cmt_err_info_o,
    output logic [63:0]                cmt_retire_cnt_o,
    output logic [CmtW-1:0][4:0]       rf_waddr_o,
    output logic [CmtW-1:0][RegW-1:0]  rf_wdata_o,
    output logic [CmtW-1:0]            rf_we_o,
    output logic [4:0]                 rf_ls_waddr_o,
    output logic [RegW-1:0]            rf_ls_wdata_o,
    output logic                       rf_ls_we_o
);

    typedef enum logic {
        IDLE,
        ERR
    } state_e;

    state_e                     state_q, state_d;
    cmt_err_info_t              err_info_q;
    logic [63:0]                retire_cnt_q;

    logic [CmtW-1:0][NumPl-1:0] sel;
    logic [CmtW-1:0]            avail;
    logic [CmtW-1:0]            err;
    logic [CmtW-1:0]            deq;
    logic [CmtW-1:0]            slot_we;
    logic [CmtW-1:0]            slot_wrsv;
    logic [CmtW-1:0]            slot_is_ls;
    logic [CmtW-1:0][4:0]       slot_waddr;
    logic [CmtW-1:0][RegW-1:0]  slot_wdata;
    logic [CmtW-1:0]            jal_marker;
    logic                       chain_ok;
    logic [NumPl-1:0]           claimed;
    logic [2:0]                 retire_inc;
    logic                       ls_fire;
    logic                       ls_kill;
    cmt_err_info_t              fault_info;
    logic                       fault_seen;
    logic                       unused_inputs;

    // Per-slot pipeline selection and AND-OR mux of the selected pipeline output.
    always_comb begin
        sel        = '0;
        avail      = '0;
        err        = '0;
        slot_we    = '0;
        slot_wrsv  = '0;
        slot_is_ls = '0;
        slot_waddr = '0;
        slot_wdata = '0;
        jal_marker = '0;
        for (int unsigned k = 0; k < CmtW; k++) begin
            sel[k]        = sbdfifo_rdata_i[k].pl[NumPl:1] & {NumPl{sbdfifo_rd_valid_i[k]}};
            jal_marker[k] = sbdfifo_rdata_i[k].pl[0];
            avail[k]      = |(sel[k] & pl_valid_i);
            slot_is_ls[k] = sel[k][LsPl-1];
            for (int unsigned p = 0; p < NumPl; p++) begin
                if (sel[k][p]) begin
                    err[k]        = err[k] | (pl_valid_i[p] & pl_output_i[p].err);
                    slot_we[k]    = slot_we[k] | pl_output_i[p].we;
                    slot_wrsv[k]  = slot_wrsv[k] | pl_output_i[p].wrsv;
                    slot_waddr[k] = slot_waddr[k] | pl_output_i[p].waddr;
                    slot_wdata[k] = slot_wdata[k] | pl_output_i[p].wdata;
                end
            end
        end
    end

    // In-order dequeue chain: stops at the first unavailable, faulting or
    // pipeline-conflicting slot; a faulting slot itself is still dequeued.
    always_comb begin
        chain_ok   = (state_q == IDLE) && !cmt_flush_i;
        claimed    = '0;
        deq        = '0;
        retire_inc = '0;
        pl_rdy_o   = '0;
        for (int unsigned k = 0; k < CmtW; k++) begin
            deq[k]     = chain_ok & avail[k] & ~|(sel[k] & claimed);
            chain_ok   = deq[k] & ~err[k];
            claimed    = claimed | sel[k];
            retire_inc = retire_inc + 3'(deq[k] & ~err[k]);
            for (int unsigned p = 0; p < NumPl; p++) begin
                pl_rdy_o[p] = pl_rdy_o[p] | (deq[k] & sel[k][p]);
            end
        end
        sbdfifo_rd_rdy_o = deq;
    end

    always_comb begin
        rf_we_o    = '0;
        rf_waddr_o = slot_waddr;
        rf_wdata_o = slot_wdata;
        for (int unsigned k = 0; k < CmtW; k++) begin
            rf_we_o[k] = deq[k] & ~err[k] & slot_we[k] & ~slot_is_ls[k];
        end
    end

    // Load write is dropped when a younger slot writes the same register this cycle.
    always_comb begin
        rf_ls_waddr_o = pl_output_i[LsPl-1].waddr;
        rf_ls_wdata_o = pl_output_i[LsPl-1].wdata;
        ls_fire       = 1'b0;
        ls_kill       = 1'b0;
        for (int unsigned k = 0; k < CmtW; k++) begin
            if (ls_fire && rf_we_o[k] && (rf_waddr_o[k] == rf_ls_waddr_o)) begin
                ls_kill = 1'b1;
            end
            if (deq[k] && !err[k] && slot_is_ls[k] && slot_we[k]) begin
                ls_fire = 1'b1;
            end
        end
        rf_ls_we_o = ls_fire & ~ls_kill;
    end

    always_comb begin
        cmt_regwr_o = '0;
        for (int unsigned k = 0; k < CmtW; k++) begin
            if (rf_we_o[k] && slot_wrsv[k]) begin
                cmt_regwr_o[rf_waddr_o[k]] = 1'b1;
            end
        end
        if (rf_ls_we_o && pl_output_i[LsPl-1].wrsv) begin
            cmt_regwr_o[rf_ls_waddr_o] = 1'b1;
        end
        cmt_regwr_o[0] = 1'b0;
    end

    // The chain ends at the first fault, so at most one dequeued slot faults.
    always_comb begin
        fault_info = NULL_CMT_ERR_INFO;
        fault_seen = 1'b0;
        for (int unsigned k = 0; k < CmtW; k++) begin
            if (deq[k] && err[k]) begin
                fault_seen = 1'b1;
                for (int unsigned p = 0; p < NumPl; p++) begin
                    if (sel[k][p]) begin
                        fault_info.pc     = fault_info.pc | pl_output_i[p].pc;
                        fault_info.mcause = fault_info.mcause | pl_output_i[p].mcause;
                        fault_info.mtval  = fault_info.mtval | pl_output_i[p].mtval;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (fault_seen) state_d = ERR;
            ERR:  if (cmt_flush_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            err_info_q   <= NULL_CMT_ERR_INFO;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            if (state_q == IDLE && state_d == ERR) begin
                err_info_q <= fault_info;
            end
            retire_cnt_q <= retire_cnt_q + 64'(retire_inc);
        end
    end

    assign cmt_err_o        = (state_q == ERR);
    assign cmt_err_info_o   = err_info_q;
    assign cmt_retire_cnt_o = retire_cnt_q;
    assign unused_inputs    = ^jal_marker ^ CHERIoTEn;

endmodule
